tm1638_frame_sequencer: RTL
===========================

# tm1638_frame_sequencer

Transaction sequencer for the TM1638 LED/7-segment driver in the clock display. On a start request, or periodically when auto-refresh is enabled, it sends one complete display frame over the TM1638 three-wire bus (STB, CLK, DIO):
- data-command transaction;
- address-plus-16-data-byte transaction;
- display-control transaction.

Bit timing comes from an internal half-period tick counter running off the single system clock, not from a derived clock.

## Interface
Parameters:
- CLK_DIV, 25: system clocks per bus half-period; legal range ≥ 2.
- REFRESH_CYCLES, 50000: idle cycles between automatic frames. Used only with TM1638_AUTO_REFRESH_EN.

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1: system clock; all logic is on its rising edge.
- RST, in, 1: synchronous active-high reset.
- start, in, 1: frame request; sampled only in IDLE.
- seg_data, in, 128: 16 display bytes; byte k = seg_data[8k+7:8k], written to TM1638 address k.
- brightness, in, 3: pulse-width setting, 0–7.
- display_on, in, 1: display enable bit.
- stb, out, 1: TM1638 STB; active low.
- sclk, out, 1: TM1638 CLK; idles high.
- dio, out, 1: TM1638 DIO; idles high.
- busy, out, 1: frame in progress.
- done, out, 1: one-cycle pulse at frame end.

## Operation
- Reset values: stb=1, sclk=1, dio=1, busy=0, done=0. FSM returns to IDLE and all counters clear. Reset asserted mid-frame aborts the frame on the next edge; no partial-frame completion and no done pulse.
- FSM states and transitions:
  - IDLE → LEAD, on start.
  - LEAD → BIT, always.
  - BIT → TRAIL, after the last bit of the transaction.
  - TRAIL → GAP, always.
  - GAP → LEAD, if another transaction remains.
  - GAP → IDLE, after transaction 2; pulse done.
- Phase lengths: every phase except IDLE lasts whole half-periods.
  - LEAD: stb=0, sclk=1; 1 half-period.
  - BIT: 2 half-periods per bit. Low half: sclk=0, dio=current bit. High half: sclk=1, dio held.
  - TRAIL: stb=0, sclk=1, dio=1; 1 half-period.
  - GAP: stb=1; 2 half-periods.
- Bit order: LSB first within every byte.
- Transactions, in order:
  - T0: 8'h40 (write data, auto-increment).
  - T1: 8'hC0, then bytes 0..15.
  - T2: 8'h80 | {display_on, brightness}; e.g. on=1, brightness=7 gives 8'h8F.
- Start acceptance: start in IDLE latches seg_data, brightness and display_on into shadow registers. Input changes while busy do not affect the current frame. start while busy is ignored, not queued.
- Widths:
  - half-period counter: $clog2(CLK_DIV) bits, counts 0..CLK_DIV-1, wraps to 0 and emits a tick at CLK_DIV-1;
  - bit counter: 3 bits;
  - byte counter: 5 bits (0..16);
  - transaction index: 2 bits.

## Timing
- Frame length is 316 half-periods:
  - T0: 20 half-periods;
  - T1: 1+272+1+2 = 276 half-periods;
  - T2: 20 half-periods.
- start high in IDLE at cycle N:
  - busy=1 and stb=0 from cycle N+1;
  - busy high for exactly 316·CLK_DIV cycles;
  - done=1 with busy=0 at cycle N+1+316·CLK_DIV.
- A start asserted in the done cycle is accepted; the next frame begins the following cycle.
- dio changes only on the same clock edge as sclk falling, so it is stable for a full half-period before each sclk rising edge.

## Configuration
- TM1638_AUTO_REFRESH_EN defined:
  - an idle counter counts REFRESH_CYCLES cycles after done, then starts a frame as if start were asserted, latching the current inputs;
  - an external start in IDLE also starts a frame and clears the idle counter.
- Undefined: frames run only on external start; no idle counter is instantiated.

## Structure
- Package tm1638_pkg:
  - CMD_DATA_AUTOINC = 8'h40, CMD_ADDR0 = 8'hC0, CMD_DISP_BASE = 8'h80;
  - NUM_BYTES = 16;
  - the FSM state enum (IDLE, LEAD, BIT, TRAIL, GAP).
- Sub-module tm1638_half_tick: parameterised CLK_DIV counter with enable and synchronous clear, emitting the one-cycle half-period tick.

## Test plan
- Reset defaults, CLK_DIV=4: RST held 3 cycles → stb=1, sclk=1, dio=1, busy=0, done=0.
- Full frame: CLK_DIV=4, seg_data=128'h0F0E…0100, brightness=5, display_on=1, start at N → bus-monitor decodes 40 | C0 00 01 … 0F | 8D; done at N+1265.
- Start while busy: second start at N+100 → ignored; exactly one done pulse. Change seg_data at N+10 → decoded frame still carries the latched values.
- Reset mid-frame: RST during T1 byte 5 → next cycle stb=1, sclk=1, busy=0, no done pulse. A following start yields a complete, correct frame.
- Back-to-back: start held high continuously → consecutive frames; each done is followed by stb=0 on the next cycle.
- Auto refresh (TM1638_AUTO_REFRESH_EN, REFRESH_CYCLES=10, CLK_DIV=2): one start → done pulses spaced 632+10+1 cycles apart. display_on=0 → T2 decodes 8'h85 with brightness=5.

Source files
------------

// File: rtl/tm1638_pkg.sv
// Shared constants, FSM state encoding and frame-byte lookup for the TM1638 frame sequencer.
// Optional build macro TM1638_AUTO_REFRESH_EN is consumed by tm1638_frame_sequencer only.
package tm1638_pkg;

    localparam logic [7:0] CMD_DATA_AUTOINC = 8'h40;
    localparam logic [7:0] CMD_ADDR0        = 8'hC0;
    localparam logic [7:0] CMD_DISP_BASE    = 8'h80;
    localparam int         NUM_BYTES        = 16;
    localparam logic [1:0] LAST_TRANS       = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        BIT,
        TRAIL,
        GAP
    } state_t;

    // Byte idx of transaction trans; in T1, idx 0 is the address command and idx k is display byte k-1.
    function automatic logic [7:0] frame_byte(
        input logic [1:0]   trans,
        input logic [4:0]   idx,
        input logic [127:0] seg,
        input logic [2:0]   bright,
        input logic         disp_on
    );
        logic [3:0] k;
        logic [7:0] b;
        k = idx[3:0] - 4'd1;
        case (trans)
            2'd0:    b = CMD_DATA_AUTOINC;
            2'd1:    b = (idx == 5'd0) ? CMD_ADDR0 : seg[{k, 3'b000} +: 8];
            default: b = CMD_DISP_BASE | {4'b0000, disp_on, bright};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/tm1638_half_tick.sv
// Half-period timebase: counts 0..CLK_DIV-1 while enabled and flags the last count as a tick.
// Not affected by TM1638_AUTO_REFRESH_EN.
module tm1638_half_tick #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic RST,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int         W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    // NOTE: registers are written with <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (RST || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/tm1638_frame_sequencer.sv
// Sends one TM1638 display frame (data cmd, address + 16 bytes, display control) per request.
// Define TM1638_AUTO_REFRESH_EN to restart frames automatically REFRESH_CYCLES idle cycles after done.
module tm1638_frame_sequencer
    import tm1638_pkg::*;
#(
    parameter int CLK_DIV        = 25,
    parameter int REFRESH_CYCLES = 50000
) (
    input  logic         clk,
    input  logic         RST,
    input  logic         start,
    input  logic [127:0] seg_data,
    input  logic [2:0]   brightness,
    input  logic         display_on,
    output logic         stb,
    output logic         sclk,
    output logic         dio,
    output logic         busy,
    output logic         done
);

    if (CLK_DIV < 2 || REFRESH_CYCLES < 1) begin : g_bad_param
        $error("tm1638_frame_sequencer: CLK_DIV must be >= 2 and REFRESH_CYCLES >= 1");
    end

    state_t       state;
    logic         second_half;
    logic [2:0]   bit_cnt;
    logic [4:0]   byte_cnt;
    logic [1:0]   trans;
    logic [127:0] seg_q;
    logic [2:0]   bright_q;
    logic         on_q;

    logic         tick;
    logic         tick_en;
    logic         tick_clr;
    logic         go;

    assign tick_en  = (state != IDLE);
    assign tick_clr = (state == IDLE);

    tm1638_half_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_half_tick (
        .clk  (clk),
        .RST  (RST),
        .en   (tick_en),
        .clr  (tick_clr),
        .tick (tick)
    );

    logic [4:0] last_byte;
    logic       last_bit;
    logic [2:0] nxt_bit_cnt;
    logic [4:0] nxt_byte_cnt;
    logic [7:0] cur_byte;
    logic [7:0] nxt_byte;
    logic       cur_dio;
    logic       nxt_dio;

    // NOTE: every always_comb output gets a default up front so no path can infer a latch.
    always_comb begin
        last_byte    = (trans == 2'd1) ? 5'(NUM_BYTES) : 5'd0;
        last_bit     = (bit_cnt == 3'd7) && (byte_cnt == last_byte);
        nxt_bit_cnt  = bit_cnt + 3'd1;
        nxt_byte_cnt = (bit_cnt == 3'd7) ? byte_cnt + 5'd1 : byte_cnt;
        cur_byte     = frame_byte(trans, byte_cnt, seg_q, bright_q, on_q);
        nxt_byte     = frame_byte(trans, nxt_byte_cnt, seg_q, bright_q, on_q);
        cur_dio      = cur_byte[bit_cnt];
        nxt_dio      = nxt_byte[nxt_bit_cnt];
    end

`ifdef TM1638_AUTO_REFRESH_EN
    localparam int IDLE_W = $clog2(REFRESH_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic              armed;
    logic              frame_end;
    logic              refresh_fire;

    assign frame_end    = (state == GAP) && tick && second_half && (trans == LAST_TRANS);
    assign refresh_fire = armed && (idle_cnt == IDLE_W'(REFRESH_CYCLES));
    assign go           = start || refresh_fire;

    // Counts only after the first completed frame; any accepted frame restarts the wait.
    always_ff @(posedge clk) begin
        if (RST) begin
            idle_cnt <= '0;
            armed    <= 1'b0;
        end else begin
            if (frame_end) begin
                armed <= 1'b1;
            end
            if (state != IDLE || go) begin
                idle_cnt <= '0;
            end else if (armed && !refresh_fire) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
        end
    end
`else
    assign go = start;
`endif

    // NOTE: the shadow registers are reset too, so a frame never serialises X after power-up.
    always_ff @(posedge clk) begin
        if (RST) begin
            state       <= IDLE;
            second_half <= 1'b0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            trans       <= '0;
            seg_q       <= '0;
            bright_q    <= '0;
            on_q        <= 1'b0;
            stb         <= 1'b1;
            sclk        <= 1'b1;
            dio         <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        seg_q       <= seg_data;
                        bright_q    <= brightness;
                        on_q        <= display_on;
                        state       <= LEAD;
                        second_half <= 1'b0;
                        bit_cnt     <= '0;
                        byte_cnt    <= '0;
                        trans       <= '0;
                        stb         <= 1'b0;
                        sclk        <= 1'b1;
                        dio         <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                LEAD: begin
                    if (tick) begin
                        state       <= BIT;
                        second_half <= 1'b0;
                        sclk        <= 1'b0;
                        dio         <= cur_dio;
                    end
                end
                BIT: begin
                    if (tick) begin
                        if (!second_half) begin
                            second_half <= 1'b1;
                            sclk        <= 1'b1;
                        end else if (last_bit) begin
                            state    <= TRAIL;
                            dio      <= 1'b1;
                            bit_cnt  <= '0;
                            byte_cnt <= '0;
                        end else begin
                            // dio only moves together with the falling sclk edge.
                            second_half <= 1'b0;
                            sclk        <= 1'b0;
                            dio         <= nxt_dio;
                            bit_cnt     <= nxt_bit_cnt;
                            byte_cnt    <= nxt_byte_cnt;
                        end
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        state       <= GAP;
                        second_half <= 1'b0;
                        stb         <= 1'b1;
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (!second_half) begin
                            second_half <= 1'b1;
                        end else if (trans == LAST_TRANS) begin
                            state       <= IDLE;
                            second_half <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            state       <= LEAD;
                            second_half <= 1'b0;
                            trans       <= trans + 2'd1;
                            stb         <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
